// File: rtl/ttl_pkg.sv
// Shared types and helpers for the TTL-style serial feeder blocks.
package ttl_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        LOADED   = 2'd1,
        SHIFTING = 2'd2
    } piso_state_t;

    localparam int unsigned TTL_DEF_WIDTH = 8;

    // Counter width for a modulo-width count, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/ttl_bit_counter.sv
// Modulo-WIDTH bit counter with synchronous clear, enable and terminal count.
module ttl_bit_counter
    import ttl_pkg::*;
#(
    parameter int unsigned WIDTH = TTL_DEF_WIDTH,
    parameter int unsigned CNT_W = clog2_min1(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc_c
);

    assign tc_c = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ttl_piso_shift_165.sv
// SN74165-style parallel-in/serial-out shift register with bit counter and word strobe.
// Optional macro TTL_OUT_TRISTATE_EN: Q_H/Q_H_N float while OC is high.
module ttl_piso_shift_165
    import ttl_pkg::*;
#(
    parameter int unsigned WIDTH = TTL_DEF_WIDTH,
    localparam int unsigned CNT_W = clog2_min1(WIDTH)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             SH_LD,
    input  logic             CLK_INH,
    input  logic             SER,
    input  logic [WIDTH-1:0] D,
    input  logic             OC,
    output logic             Q_H,
    output logic             Q_H_N,
    output logic             WORD_DONE,
    output logic [CNT_W-1:0] BIT_CNT,
    output logic             BUSY
);

    piso_state_t      state;
    piso_state_t      state_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic             q_n;
    logic             busy_q;
    logic             done_q;
    logic             load_c;
    logic             shift_c;
    logic             cnt_en_c;
    logic             tc_c;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Load wins over inhibit; only a counted shift can finish a word.
    always_comb begin
        state_next = state;
        if (!SH_LD) begin
            state_next = LOADED;
        end else if (!CLK_INH) begin
            case (state)
                EMPTY:            state_next = EMPTY;
                LOADED, SHIFTING: state_next = tc_c ? EMPTY : SHIFTING;
                default:          state_next = EMPTY;
            endcase
        end
    end

    // Shifts in EMPTY move data but are not part of a loaded word.
    always_comb begin
        load_c   = 1'b0;
        shift_c  = 1'b0;
        cnt_en_c = 1'b0;
        load_c   = !SH_LD;
        shift_c  = SH_LD && !CLK_INH;
        cnt_en_c = shift_c && (state != EMPTY);
    end

    ttl_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk   (CLK),
        .rst_n (CLR),
        .clr   (load_c),
        .en    (cnt_en_c),
        .count (BIT_CNT),
        .tc_c  (tc_c)
    );

    always_comb begin
        sreg_next = sreg;
        if (load_c) begin
            sreg_next = D;
        end else if (shift_c) begin
            sreg_next = {sreg[WIDTH-2:0], SER};
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sreg   <= '0;
            q_n    <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sreg   <= sreg_next;
            q_n    <= ~sreg_next[WIDTH-1];
            busy_q <= (state_next == SHIFTING);
            done_q <= cnt_en_c && tc_c;
        end
    end

    assign WORD_DONE = done_q;
    assign BUSY      = busy_q;

`ifdef TTL_OUT_TRISTATE_EN
    assign Q_H   = OC ? 1'bz : sreg[WIDTH-1];
    assign Q_H_N = OC ? 1'bz : q_n;
`else
    logic unused_oc;
    assign unused_oc = OC;
    assign Q_H       = sreg[WIDTH-1];
    assign Q_H_N     = q_n;
`endif

endmodule

// File: tb/tb_ttl_piso_shift_165.sv
// Self-checking bench for ttl_piso_shift_165 (WIDTH=8) with a reference-model scoreboard.
module tb_ttl_piso_shift_165;

    logic       CLK;
    logic       CLR;
    logic       SH_LD;
    logic       CLK_INH;
    logic       SER;
    logic [7:0] D;
    logic       OC;
    logic       Q_H;
    logic       Q_H_N;
    logic       WORD_DONE;
    logic [2:0] BIT_CNT;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    // Expected {Q_H, Q_H_N, BIT_CNT[2:0], WORD_DONE, BUSY}
    typedef logic [6:0] exp_t;
    exp_t sb[$];

    logic [7:0] m_reg;
    int         m_cnt;
    int         m_state;
    logic       m_done;

    ttl_piso_shift_165 #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .SH_LD     (SH_LD),
        .CLK_INH   (CLK_INH),
        .SER       (SER),
        .D         (D),
        .OC        (OC),
        .Q_H       (Q_H),
        .Q_H_N     (Q_H_N),
        .WORD_DONE (WORD_DONE),
        .BIT_CNT   (BIT_CNT),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic exp_t obs();
        return {Q_H, Q_H_N, BIT_CNT, WORD_DONE, BUSY};
    endfunction

    task automatic model_reset();
        m_reg   = 8'h00;
        m_cnt   = 0;
        m_state = 0;
        m_done  = 1'b0;
        sb.delete();
    endtask

    // Drive one clock of stimulus, advance the model and queue its prediction.
    task automatic cycle(input logic sh_ld, input logic inh, input logic ser, input logic [7:0] d);
        SH_LD   = sh_ld;
        CLK_INH = inh;
        SER     = ser;
        D       = d;
        if (!sh_ld) begin
            m_reg   = d;
            m_cnt   = 0;
            m_state = 1;
            m_done  = 1'b0;
        end else if (!inh) begin
            m_reg = {m_reg[6:0], ser};
            if (m_state == 0) begin
                m_done = 1'b0;
            end else if (m_cnt == 7) begin
                m_cnt   = 0;
                m_done  = 1'b1;
                m_state = 0;
            end else begin
                m_cnt   = m_cnt + 1;
                m_done  = 1'b0;
                m_state = 2;
            end
        end else begin
            m_done = 1'b0;
        end
        sb.push_back({m_reg[7], ~m_reg[7], 3'(m_cnt), m_done, (m_state == 2)});
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        CLR = 1'b1; SH_LD = 1'b1; CLK_INH = 1'b1; SER = 1'b0; D = 8'h00; OC = 1'b0;
        #2 CLR = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs() !== 7'b0100000) begin
            errors++;
            $display("FAIL reset_init: got %b want %b", obs(), 7'b0100000);
        end
        @(negedge CLK) CLR = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h00);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (sb.size() == 0) begin
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("FAIL reset_preshift: got %b want %b", obs(), e);
                end
            end
        end
        checks++;
        if (BIT_CNT !== 3'd3) begin
            errors++;
            $display("FAIL reset_cnt3: got %0d want 3", BIT_CNT);
        end
        #2 CLR = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs() !== 7'b0100000) begin
            errors++;
            $display("FAIL reset_midshift: got %b want %b", obs(), 7'b0100000);
        end
        @(negedge CLK) CLR = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h00);
            e = sb.pop_front();
            checks++;
            if (WORD_DONE !== 1'b0 || obs() !== e) begin
                errors++;
                $display("FAIL reset_nodone: got %b want %b", obs(), e);
            end
        end
    endtask

    task automatic test_load_shift();
        exp_t       e;
        logic [7:0] pat;
        pat = 8'hA5;
        cycle(1'b0, 1'b0, 1'b0, pat);
        e = sb.pop_front();
        checks++;
        if (obs() !== e || Q_H !== 1'b1) begin
            errors++;
            $display("FAIL load_a5: got %b want %b", obs(), e);
        end
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h00);
            e = sb.pop_front();
            checks++;
            if (obs() !== e || Q_H !== ((k < 8) ? pat[7-k] : 1'b0) || WORD_DONE !== (k == 8)) begin
                errors++;
                $display("FAIL shift_a5_%0d: got %b want %b", k, obs(), e);
            end
        end
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        e = sb.pop_front();
        checks++;
        if (obs() !== e || WORD_DONE !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: got %b want %b", obs(), e);
        end
    endtask

    task automatic test_inhibit();
        exp_t e;
        cycle(1'b0, 1'b0, 1'b0, 8'hC3);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 8'hFF);
            e = sb.pop_front();
            checks++;
            if (obs() !== e || Q_H !== 1'b1 || BIT_CNT !== 3'd0) begin
                errors++;
                $display("FAIL inhibit_hold_%0d: got %b want %b", i, obs(), e);
            end
        end
        for (int k = 1; k <= 2; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h00);
            e = sb.pop_front();
            checks++;
            if (obs() !== e || Q_H !== ((k == 1) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL inhibit_shift_%0d: got %b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_load_priority();
        exp_t e;
        cycle(1'b0, 1'b1, 1'b0, 8'h0F);
        e = sb.pop_front();
        checks++;
        if (obs() !== e || Q_H !== 1'b0 || BIT_CNT !== 3'd0) begin
            errors++;
            $display("FAIL load_over_inh: got %b want %b", obs(), e);
        end
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h00);
            e = sb.pop_front();
            checks++;
            if (obs() !== e || Q_H !== (k >= 4)) begin
                errors++;
                $display("FAIL pattern_0f_%0d: got %b want %b", k, obs(), e);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h5A);
        e = sb.pop_front();
        checks++;
        if (obs() !== e || BIT_CNT !== 3'd0 || WORD_DONE !== 1'b0) begin
            errors++;
            $display("FAIL midword_reload: got %b want %b", obs(), e);
        end
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 8'h00);
            e = sb.pop_front();
            checks++;
            if (obs() !== e || WORD_DONE !== (k == 8)) begin
                errors++;
                $display("FAIL reload_shift_%0d: got %b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_cascade();
        exp_t e;
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        e = sb.pop_front();
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 8'h00);
            e = sb.pop_front();
            checks++;
            if (obs() !== e || Q_H !== (k == 8) || Q_H_N !== (k != 8)) begin
                errors++;
                $display("FAIL cascade_%0d: got %b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 8'($urandom));
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL random_%0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_output_control();
        exp_t e;
        cycle(1'b0, 1'b0, 1'b0, 8'h3C);
        e = sb.pop_front();
        OC = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 8'h00);
            e = sb.pop_front();
            checks++;
`ifdef TTL_OUT_TRISTATE_EN
            if (Q_H !== 1'bz || Q_H_N !== 1'bz || BIT_CNT !== e[4:2] || BUSY !== e[0]) begin
                errors++;
                $display("FAIL oc_float_%0d: got %b want zz%b", k, obs(), e[4:0]);
            end
`else
            if (obs() !== e) begin
                errors++;
                $display("FAIL oc_ignored_%0d: got %b want %b", k, obs(), e);
            end
`endif
        end
        OC = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL oc_restore: got %b want %b", obs(), e);
        end
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_inhibit();
        test_load_priority();
        test_cascade();
        test_output_control();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
